// File: rtl/rom_read_arbiter_pkg.sv
// Shared constants and helpers for the ROM read arbiter.
// Default sizes, a clog2 helper and the statistics counter width.
package rom_arb_pkg;

    localparam int K_DEF    = 8;
    localparam int M_DEF    = 2;
    localparam int NREQ_DEF = 2;
    localparam int STATS_W  = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointer and winner index width; never narrower than one bit.
    function automatic int ptr_width(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: requests, addresses, grant and read return.
interface rom_read_arbiter_if #(
    parameter int NREQ = 2,
    parameter int M    = 2,
    parameter int K    = 8
) ();

    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] adr;
    logic [NREQ-1:0]   gnt;
    logic [K-1:0]      rdata;
    logic [NREQ-1:0]   rvalid;

    modport master (
        output req,
        output adr,
        input  gnt,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  req,
        input  adr,
        output gnt,
        output rdata,
        output rvalid
    );

endinterface

// File: rtl/rom_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping at NREQ-1.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    // Scan from the farthest offset down so the candidate closest to ptr is assigned last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (elig[idx]) begin
                winner = PTR_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between NREQ requesters.
// Optional ROM_ARB_STATS_EN adds conflict_cnt, a saturating count of contended cycles.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int K    = K_DEF,
    parameter int M    = M_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    rom_read_arbiter_if.slave    bus,
    output logic [M-1:0]         rom_adr,
    input  logic [K-1:0]         rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]   conflict_cnt
`endif
);

    localparam int PTR_W = ptr_width(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  rvalid_q;
    logic [K-1:0]     rdata_q;
    logic [NREQ-1:0]  elig;
    logic [PTR_W-1:0] winner;
    logic             any;

    // A requester still shows req during its own grant cycle; masking stops a re-grant.
    assign elig = bus.req & ~gnt_q;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rom_adr  <= '0;
            ptr      <= '0;
        end else begin
            rvalid_q <= gnt_q;
            if (gnt_q != '0) begin
                rdata_q <= rom_data;
            end
            if (any) begin
                gnt_q   <= NREQ'(1) << winner;
                rom_adr <= bus.adr[int'(winner) * M +: M];
                ptr     <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            end else begin
                gnt_q   <= '0;
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

`ifdef ROM_ARB_STATS_EN
    logic conflict;

    assign conflict = (elig & (elig - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a 4-entry ROM model (entry n holds n+5).
module tb_rom_read_arbiter;

    localparam int K    = 8;
    localparam int M    = 2;
    localparam int NREQ = 2;

    logic         clk;
    logic         rst;
    logic [M-1:0] rom_adr;
    logic [K-1:0] rom_data;
    int           checks;
    int           failures;

    rom_read_arbiter_if #(.NREQ(NREQ), .M(M), .K(K)) bus ();

    assign rom_data = K'(rom_adr) + K'(5);

`ifdef ROM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic        rst3;
    logic [1:0]  rom_adr3;
    logic [15:0] conflict_cnt3;
    rom_read_arbiter_if #(.NREQ(3), .M(M), .K(K)) bus3 ();
`endif

    rom_read_arbiter #(.K(K), .M(M), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rom_adr  (rom_adr),
        .rom_data (rom_data)
`ifdef ROM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

`ifdef ROM_ARB_STATS_EN
    rom_read_arbiter #(.K(K), .M(M), .NREQ(3)) dut3 (
        .clk          (clk),
        .rst          (rst3),
        .bus          (bus3.slave),
        .rom_adr      (rom_adr3),
        .rom_data     (K'(rom_adr3) + K'(5)),
        .conflict_cnt (conflict_cnt3)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_adr(input logic [M-1:0] a0, input logic [M-1:0] a1);
        bus.adr = {a1, a0};
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = 2'b11;
        set_adr(2'd0, 2'd3);
`ifdef ROM_ARB_STATS_EN
        rst3     = 1'b1;
        bus3.req = 3'b000;
        bus3.adr = '0;
`endif

        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_gnt", 32'(bus.gnt), 32'h0);
            check("rst_rvalid", 32'(bus.rvalid), 32'h0);
            check("rst_rdata", 32'(bus.rdata), 32'h0);
            check("rst_rom_adr", 32'(rom_adr), 32'h0);
        end

        // Single read from requester 0 at address 2.
        rst     = 1'b0;
        bus.req = 2'b01;
        set_adr(2'd2, 2'd0);
        step();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_rom_adr", 32'(rom_adr), 32'h2);
        bus.req = 2'b00;
        step();
        check("t1_rvalid", 32'(bus.rvalid), 32'h1);
        check("t1_rdata", 32'(bus.rdata), 32'h7);
        check("t1_gnt_idle", 32'(bus.gnt), 32'h0);

        // Both request together from ptr=0.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 2'b11;
        set_adr(2'd0, 2'd3);
        step();
        check("t2_gnt0", 32'(bus.gnt), 32'h1);
        check("t2_rom_adr0", 32'(rom_adr), 32'h0);
        bus.req = 2'b10;
        step();
        check("t2_gnt1", 32'(bus.gnt), 32'h2);
        check("t2_rom_adr1", 32'(rom_adr), 32'h3);
        check("t2_rvalid0", 32'(bus.rvalid), 32'h1);
        check("t2_rdata0", 32'(bus.rdata), 32'h5);
`ifdef ROM_ARB_STATS_EN
        check("t2_conflicts", 32'(conflict_cnt), 32'h1);
`endif
        bus.req = 2'b00;
        step();
        check("t2_gnt_idle", 32'(bus.gnt), 32'h0);
        check("t2_rvalid1", 32'(bus.rvalid), 32'h2);
        check("t2_rdata1", 32'(bus.rdata), 32'h8);

        // Continuous contention: grants must alternate, never the same requester twice in a row.
        bus.req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t3_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                check("t3_rvalid", 32'(bus.rvalid), (k % 2 == 1) ? 32'h1 : 32'h2);
                check("t3_rdata", 32'(bus.rdata), (k % 2 == 1) ? 32'h5 : 32'h8);
            end
        end
`ifdef ROM_ARB_STATS_EN
        check("t3_conflicts", 32'(conflict_cnt), 32'h2);
`endif

        // Reset during a grant to requester 0 discards that read and restores ptr=0.
        bus.req = 2'b01;
        set_adr(2'd1, 2'd3);
        step();
        check("t4_gnt", 32'(bus.gnt), 32'h1);
        check("t4_rom_adr", 32'(rom_adr), 32'h1);
        rst     = 1'b1;
        bus.req = 2'b11;
        step();
        check("t4_rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("t4_rst_rdata", 32'(bus.rdata), 32'h0);
        check("t4_rst_gnt", 32'(bus.gnt), 32'h0);
`ifdef ROM_ARB_STATS_EN
        check("t4_rst_conflicts", 32'(conflict_cnt), 32'h0);
`endif
        rst = 1'b0;
        step();
        check("t4_first_gnt", 32'(bus.gnt), 32'h1);
        check("t4_first_rom_adr", 32'(rom_adr), 32'h1);

        // A request withdrawn before the sampling edge leaves no trace.
        bus.req = 2'b00;
        step();
        step();
        check("t5_gnt_none", 32'(bus.gnt), 32'h0);
        check("t5_rvalid_none", 32'(bus.rvalid), 32'h0);
        check("t5_rdata_hold", 32'(bus.rdata), 32'h6);

`ifdef ROM_ARB_STATS_EN
        // Three always-requesting clients contend every cycle, driving the counter to saturation.
        step();
        rst3     = 1'b0;
        bus3.req = 3'b111;
        for (int n = 0; n < 10; n++) begin
            step();
        end
        check("t6_conflicts10", 32'(conflict_cnt3), 32'd10);
        for (int n = 10; n < 65540; n++) begin
            step();
        end
        check("t6_saturated", 32'(conflict_cnt3), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
